// File: rtl/mac_firewall_if.sv
// Dibit stream into the firewall plus the filtered payload stream and frame status out.
interface mac_firewall_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [1:0]  axiod;
  logic [15:0] etype;
  logic        frame_done;
  logic        frame_drop;

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, etype, frame_done, frame_drop
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, etype, frame_done, frame_drop
  );
endinterface

// File: rtl/mac_firewall.sv
// Ethernet destination filter on an MSb-first dibit stream: strips the 14-byte header
// and forwards payload dibits of frames for this station (or broadcast), one cycle late.
module mac_firewall #(
  parameter logic [47:0] MY_MAC      = 48'h69_69_5A_06_54_91,
  parameter bit          ALLOW_BCAST = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mac_firewall_if.slave fw
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_DST,
    S_HDR,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [5:0] LAST_DST    = 6'd23;
  localparam logic [5:0] ETYPE_FIRST = 6'd48;
  localparam logic [5:0] LAST_HDR    = 6'd55;
  localparam logic [5:0] CNT_MAX     = 6'd56;

  // Expected destination dibit per position; padded to 32 so any counter value indexes safely.
  logic [1:0] mac_dibit [32];
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_mac
      if (gi < 24) begin : g_used
        assign mac_dibit[gi] = MY_MAC[47-2*gi -: 2];
      end else begin : g_pad
        assign mac_dibit[gi] = 2'b00;
      end
    end
  endgenerate

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic        me_q;
  logic        bc_q;
  logic [15:0] etype_sr_q;
  logic [15:0] etype_q;
  logic        etype_load_q;
  logic        axiov_q;
  logic [1:0]  axiod_q;
  logic        frame_done_q;
  logic        frame_drop_q;

  logic        me_d;
  logic        bc_d;
  logic        addr_ok;
  logic [5:0]  cnt_d;

  // In IDLE the counter is 0, so the same lookup yields the first dibit of MY_MAC.
  always_comb begin
    me_d    = ((state_q == S_IDLE) ? 1'b1 : me_q) & (fw.axiid == mac_dibit[cnt_q[4:0]]);
    bc_d    = ((state_q == S_IDLE) ? 1'b1 : bc_q) & (fw.axiid == 2'b11);
    addr_ok = me_d | (ALLOW_BCAST & bc_d);
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT;
      cnt_q        <= '0;
      me_q         <= 1'b0;
      bc_q         <= 1'b0;
      etype_sr_q   <= '0;
      etype_q      <= '0;
      etype_load_q <= 1'b0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
      etype_load_q <= 1'b0;
      if (etype_load_q) etype_q <= etype_sr_q;

      case (state_q)
        S_WAIT: begin
          if (!fw.axiiv) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (fw.axiiv) begin
            state_q <= S_DST;
            cnt_q   <= 6'd1;
            me_q    <= me_d;
            bc_q    <= bc_d;
          end
        end
        S_DST: begin
          if (!fw.axiiv) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            frame_drop_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            me_q  <= me_d;
            bc_q  <= bc_d;
            if (cnt_q == LAST_DST) begin
              state_q      <= addr_ok ? S_HDR : S_DROP;
              frame_drop_q <= !addr_ok;
            end
          end
        end
        S_HDR: begin
          if (!fw.axiiv) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            frame_drop_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_q >= ETYPE_FIRST) etype_sr_q <= {etype_sr_q[13:0], fw.axiid};
            if (cnt_q == LAST_HDR) begin
              state_q      <= S_PAYLOAD;
              etype_load_q <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (!fw.axiiv) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            frame_done_q <= 1'b1;
          end else begin
            cnt_q   <= cnt_d;
            axiov_q <= 1'b1;
            axiod_q <= fw.axiid;
          end
        end
        S_DROP: begin
          // The rejection was already reported when the address was decided.
          if (!fw.axiiv) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fw.axiov      = axiov_q;
  assign fw.axiod      = axiod_q;
  assign fw.etype      = etype_q;
  assign fw.frame_done = frame_done_q;
  assign fw.frame_drop = frame_drop_q;

endmodule

// File: tb/tb_mac_firewall.sv
// Bench for mac_firewall: two instances (broadcast allowed / not) see the same dibit stream;
// a frame-level model predicts payload dibits, pulse cycles and EtherType for each.
module tb_mac_firewall;
  localparam logic [47:0] MY = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BC = 48'hFF_FF_FF_FF_FF_FF;

  typedef logic [7:0] byte_q_t [$];

  typedef struct {
    string       name;
    logic [47:0] dst;
    logic [15:0] ety;
    int          npay;
    int          ndib;
    int          done_a, drop_a, pay_a;
    int          done_b, drop_b, pay_b;
    logic [15:0] ety_a, ety_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [1:0] dat = 2'b00;
  int         cyc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_firewall_if if_a ();
  mac_firewall_if if_b ();

  assign if_a.axiiv = vld;
  assign if_a.axiid = dat;
  assign if_b.axiiv = vld;
  assign if_b.axiid = dat;

  mac_firewall #(.MY_MAC(MY), .ALLOW_BCAST(1'b1)) dut_a (.clk(clk), .rst(rst), .fw(if_a));
  mac_firewall #(.MY_MAC(MY), .ALLOW_BCAST(1'b0)) dut_b (.clk(clk), .rst(rst), .fw(if_b));

  logic        m_ov   [2];
  logic [1:0]  m_od   [2];
  logic        m_done [2];
  logic        m_drop [2];
  logic [15:0] m_ety  [2];

  assign m_ov[0] = if_a.axiov;       assign m_ov[1] = if_b.axiov;
  assign m_od[0] = if_a.axiod;       assign m_od[1] = if_b.axiod;
  assign m_done[0] = if_a.frame_done; assign m_done[1] = if_b.frame_done;
  assign m_drop[0] = if_a.frame_drop; assign m_drop[1] = if_b.frame_drop;
  assign m_ety[0] = if_a.etype;      assign m_ety[1] = if_b.etype;

  // Observed events (absolute cycle numbers) and invariant violations.
  int         got_pay_cyc [2][$];
  logic [1:0] got_pay_d   [2][$];
  int         got_done    [2][$];
  int         got_drop    [2][$];
  int         inv_cnt     [2];

  // Predicted events.
  int          exp_pay_cyc [2][$];
  logic [1:0]  exp_pay_d   [2][$];
  int          exp_done    [2][$];
  int          exp_drop    [2][$];
  logic [15:0] exp_ety     [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_ov[k]) begin
        got_pay_cyc[k].push_back(cyc);
        got_pay_d[k].push_back(m_od[k]);
      end
      if (m_done[k]) got_done[k].push_back(cyc);
      if (m_drop[k]) got_drop[k].push_back(cyc);
      if ((!m_ov[k] && m_od[k] != 2'b00) || (m_done[k] && m_drop[k]))
        inv_cnt[k] <= inv_cnt[k] + 1;
    end
  end

  task automatic check(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic mk_frame(input logic [47:0] dst, input logic [15:0] ety, input int npay,
                          input bit fixed, output byte_q_t b);
    logic [31:0] deadbeef;
    deadbeef = 32'hDEAD_BEEF;
    b = {};
    for (int j = 0; j < 6; j++) b.push_back(8'(dst >> (40 - 8*j)));
    b.push_back(8'h00); b.push_back(8'h11); b.push_back(8'h22);
    b.push_back(8'h33); b.push_back(8'h44); b.push_back(8'h55);
    b.push_back(ety[15:8]);
    b.push_back(ety[7:0]);
    for (int j = 0; j < npay; j++)
      b.push_back((fixed && j < 4) ? 8'(deadbeef >> (24 - 8*j)) : 8'($urandom));
  endtask

  // Drives ndib dibits back to back, then one idle cycle.
  task automatic send_frame(input byte_q_t b, input int ndib, output int start);
    logic [7:0] tmp;
    start = 0;
    for (int i = 0; i < ndib; i++) begin
      @(negedge clk);
      if (i == 0) start = cyc;
      tmp = b[i/4];
      vld = 1'b1;
      dat = tmp[7-2*(i%4) -: 2];
    end
    @(negedge clk);
    vld = 1'b0;
    dat = 2'b00;
  endtask

  // Frame-level prediction: address decision from the first six bytes, header is 56 dibits,
  // everything after it is payload delayed by one cycle; pulses follow the end-of-frame rules.
  task automatic expect_frame(input int k, input byte_q_t b, input int n, input int s,
                              input bit aborted);
    logic [47:0] dst;
    logic [7:0]  by;
    bit          acc;
    dst = {b[0], b[1], b[2], b[3], b[4], b[5]};
    acc = (dst == MY) || (k == 0 && dst == BC);
    if (n < 24) begin
      if (!aborted) exp_drop[k].push_back(s + n + 1);
    end else if (!acc) begin
      exp_drop[k].push_back(s + 24);
    end else if (n < 56) begin
      if (!aborted) exp_drop[k].push_back(s + n + 1);
    end else begin
      for (int i = 56; i < n; i++) begin
        by = b[i/4];
        exp_pay_cyc[k].push_back(s + i + 1);
        exp_pay_d[k].push_back(2'((by >> (6 - 2*(i%4))) & 8'h03));
      end
      if (!aborted) begin
        exp_done[k].push_back(s + n + 1);
        exp_ety[k] = {b[12], b[13]};
      end
    end
    if (aborted) exp_ety[k] = 16'h0000;
  endtask

  task automatic compare_dut(input int k, input string tag);
    string p;
    p = $sformatf("%s/dut%0d", tag, k);
    check({p, " payload count"}, got_pay_cyc[k].size(), exp_pay_cyc[k].size());
    for (int i = 0; i < got_pay_cyc[k].size() && i < exp_pay_cyc[k].size(); i++)
      check($sformatf("%s payload[%0d] {cycle,dibit}", p, i),
            longint'(got_pay_cyc[k][i]) * 4 + longint'(got_pay_d[k][i]),
            longint'(exp_pay_cyc[k][i]) * 4 + longint'(exp_pay_d[k][i]));
    check({p, " frame_done count"}, got_done[k].size(), exp_done[k].size());
    for (int i = 0; i < got_done[k].size() && i < exp_done[k].size(); i++)
      check({p, " frame_done cycle"}, got_done[k][i], exp_done[k][i]);
    check({p, " frame_drop count"}, got_drop[k].size(), exp_drop[k].size());
    for (int i = 0; i < got_drop[k].size() && i < exp_drop[k].size(); i++)
      check({p, " frame_drop cycle"}, got_drop[k][i], exp_drop[k][i]);
    check({p, " etype"}, m_ety[k], exp_ety[k]);
    check({p, " invariant violations"}, inv_cnt[k], 0);
    got_pay_cyc[k].delete(); got_pay_d[k].delete(); got_done[k].delete(); got_drop[k].delete();
    exp_pay_cyc[k].delete(); exp_pay_d[k].delete(); exp_done[k].delete(); exp_drop[k].delete();
  endtask

  task automatic settle_and_compare(input string tag);
    repeat (3) @(negedge clk);
    compare_dut(0, tag);
    compare_dut(1, tag);
  endtask

  task automatic run_frame(input string tag, input byte_q_t b, input int ndib);
    int s;
    send_frame(b, ndib, s);
    expect_frame(0, b, ndib, s, 1'b0);
    expect_frame(1, b, ndib, s, 1'b0);
    $display("frame %s: %0d dibits from cycle %0d", tag, ndib, s);
  endtask

  vec_t vecs [10];

  initial begin
    byte_q_t b, b2;
    int s;
    logic [47:0] dst;

    vecs[0] = '{"unicast",       MY,                 16'h0800,  4, 72, 1,0,16, 1,0,16, 16'h0800, 16'h0800};
    vecs[1] = '{"bcast",         BC,                 16'h0806,  2, 64, 1,0,8,  0,1,0,  16'h0806, 16'h0800};
    vecs[2] = '{"dst_last_mis",  MY ^ 48'h1,         16'h0800,  4, 72, 0,1,0,  0,1,0,  16'h0806, 16'h0800};
    vecs[3] = '{"runt40",        MY,                 16'h1234,  4, 40, 0,1,0,  0,1,0,  16'h0806, 16'h0800};
    vecs[4] = '{"hdr_only",      MY,                 16'h86DD,  0, 56, 1,0,0,  1,0,0,  16'h86DD, 16'h86DD};
    vecs[5] = '{"dst_first_mis", 48'h00_11_22_33_44_55, 16'h0800, 4, 72, 0,1,0, 0,1,0, 16'h86DD, 16'h86DD};
    vecs[6] = '{"runt10",        MY,                 16'h0800,  4, 10, 0,1,0,  0,1,0,  16'h86DD, 16'h86DD};
    vecs[7] = '{"bcast_runt30",  BC,                 16'h0800,  4, 30, 0,1,0,  0,1,0,  16'h86DD, 16'h86DD};
    vecs[8] = '{"near_bcast",    48'hFF_FF_FF_FF_FF_FE, 16'h0800, 4, 72, 0,1,0, 0,1,0, 16'h86DD, 16'h86DD};
    vecs[9] = '{"bcast_long",    BC,                 16'h88CC, 10, 96, 1,0,40, 0,1,0,  16'h88CC, 16'h86DD};

    exp_ety[0] = 16'h0000;
    exp_ety[1] = 16'h0000;
    inv_cnt[0] = 0;
    inv_cnt[1] = 0;

    // Reset state.
    repeat (4) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset/dut%0d axiov", k), m_ov[k], 0);
      check($sformatf("reset/dut%0d axiod", k), m_od[k], 0);
      check($sformatf("reset/dut%0d etype", k), m_ety[k], 0);
      check($sformatf("reset/dut%0d frame_done", k), m_done[k], 0);
      check($sformatf("reset/dut%0d frame_drop", k), m_drop[k], 0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed table.
    for (int v = 0; v < 10; v++) begin
      mk_frame(vecs[v].dst, vecs[v].ety, vecs[v].npay, v == 0, b);
      run_frame(vecs[v].name, b, vecs[v].ndib);
      repeat (3) @(negedge clk);
      check({vecs[v].name, "/dut0 done count"}, got_done[0].size(), vecs[v].done_a);
      check({vecs[v].name, "/dut0 drop count"}, got_drop[0].size(), vecs[v].drop_a);
      check({vecs[v].name, "/dut0 payload dibits"}, got_pay_cyc[0].size(), vecs[v].pay_a);
      check({vecs[v].name, "/dut0 etype"}, m_ety[0], vecs[v].ety_a);
      check({vecs[v].name, "/dut1 done count"}, got_done[1].size(), vecs[v].done_b);
      check({vecs[v].name, "/dut1 drop count"}, got_drop[1].size(), vecs[v].drop_b);
      check({vecs[v].name, "/dut1 payload dibits"}, got_pay_cyc[1].size(), vecs[v].pay_b);
      check({vecs[v].name, "/dut1 etype"}, m_ety[1], vecs[v].ety_b);
      compare_dut(0, vecs[v].name);
      compare_dut(1, vecs[v].name);
    end

    // Runt followed by a good frame after a single idle cycle.
    mk_frame(MY, 16'h0800, 4, 1'b0, b);
    mk_frame(MY, 16'h0801, 6, 1'b0, b2);
    run_frame("runt_then_good/runt", b, 40);
    run_frame("runt_then_good/good", b2, 80);
    settle_and_compare("runt_then_good");

    // Back-to-back: accepted, then mismatched in the last destination dibit.
    mk_frame(MY, 16'h0802, 5, 1'b0, b);
    mk_frame(MY ^ 48'h1, 16'h0803, 5, 1'b0, b2);
    run_frame("b2b/accept", b, 76);
    run_frame("b2b/reject", b2, 76);
    settle_and_compare("b2b");

    // Reset mid-payload; input keeps streaming 10 more cycles and must be ignored.
    mk_frame(MY, 16'h0804, 10, 1'b0, b);
    s = 0;
    for (int i = 0; i < 74; i++) begin
      @(negedge clk);
      if (i == 0) s = cyc;
      if (i == 65) begin
        check("reset_mid/dut0 etype after reset", m_ety[0], 0);
        check("reset_mid/dut0 axiov after reset", m_ov[0], 0);
      end
      vld = 1'b1;
      dat = 2'((b[i/4] >> (6 - 2*(i%4))) & 8'h03);
      rst = (i == 64);
    end
    @(negedge clk);
    vld = 1'b0;
    dat = 2'b00;
    expect_frame(0, b, 64, s, 1'b1);
    expect_frame(1, b, 64, s, 1'b1);
    $display("frame reset_mid: reset at dibit 64 of frame from cycle %0d", s);
    settle_and_compare("reset_mid");
    mk_frame(MY, 16'h0805, 3, 1'b0, b);
    run_frame("after_reset", b, 68);
    settle_and_compare("after_reset");

    // Randomized frames against the model.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: dst = MY;
        1: dst = BC;
        2: dst = MY ^ (48'h1 << $urandom_range(0, 47));
        default: dst = {16'($urandom), 32'($urandom)};
      endcase
      mk_frame(dst, 16'($urandom), 20, 1'b0, b);
      run_frame($sformatf("rand%0d", r), b, int'($urandom_range(1, 136)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      settle_and_compare($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
